// File: rtl/router_fsm_ctrl.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loading into the selected output FIFO and stalls the source while it is busy.
module router_fsm_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ADDR_W  = 2;

    localparam logic [STATE_W-1:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [STATE_W-1:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [STATE_W-1:0] LOAD_DATA          = 3'd2;
    localparam logic [STATE_W-1:0] FIFO_FULL_STATE    = 3'd3;
    localparam logic [STATE_W-1:0] LOAD_AFTER_FULL    = 3'd4;
    localparam logic [STATE_W-1:0] LOAD_PARITY        = 3'd5;
    localparam logic [STATE_W-1:0] CHECK_PARITY_ERROR = 3'd6;
    localparam logic [STATE_W-1:0] WAIT_TILL_EMPTY    = 3'd7;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  addr_nxt;
    logic               addr_ok;
    logic               empty_din;
    logic               empty_addr;
    logic               soft_rst_sel;

    assign addr_ok = pkt_valid && (data_in != ADDR_INVALID);

    // Emptiness of the FIFO named by the incoming header byte
    always_comb begin
        empty_din = 1'b0;
        case (data_in)
            2'd0:    empty_din = fifo_empty_0;
            2'd1:    empty_din = fifo_empty_1;
            2'd2:    empty_din = fifo_empty_2;
            default: empty_din = 1'b0;
        endcase
    end

    // Emptiness and soft reset of the FIFO currently latched as destination
    always_comb begin
        empty_addr   = 1'b0;
        soft_rst_sel = 1'b0;
        case (addr)
            2'd0: begin
                empty_addr   = fifo_empty_0;
                soft_rst_sel = soft_reset_0;
            end
            2'd1: begin
                empty_addr   = fifo_empty_1;
                soft_rst_sel = soft_reset_1;
            end
            2'd2: begin
                empty_addr   = fifo_empty_2;
                soft_rst_sel = soft_reset_2;
            end
            default: begin
                empty_addr   = 1'b0;
                soft_rst_sel = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DECODE_ADDRESS;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    // Next-state logic; a timed-out destination FIFO aborts the packet
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        if ((state == DECODE_ADDRESS) && addr_ok) begin
            addr_nxt = data_in;
        end
        if (soft_rst_sel) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (addr_ok) begin
                        state_nxt = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_nxt = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_nxt = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_nxt = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_nxt = DECODE_ADDRESS;
                    end else if (low_packet_valid) begin
                        state_nxt = LOAD_PARITY;
                    end else begin
                        state_nxt = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_addr) begin
                        state_nxt = LOAD_FIRST_DATA;
                    end
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore decodes of the registered state only
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
            WAIT_TILL_EMPTY:    busy          = 1'b1;
            default: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: directed packet scenarios with literal checks,
// then randomized traffic compared each cycle against a behavioural model.
module tb_router_fsm_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg, busy;

    int checks   = 0;
    int failures = 0;

    router_fsm_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .pkt_valid       (pkt_valid),
        .data_in         (data_in),
        .fifo_full       (fifo_full),
        .fifo_empty_0    (fifo_empty_0),
        .fifo_empty_1    (fifo_empty_1),
        .fifo_empty_2    (fifo_empty_2),
        .soft_reset_0    (soft_reset_0),
        .soft_reset_1    (soft_reset_1),
        .soft_reset_2    (soft_reset_2),
        .parity_done     (parity_done),
        .low_packet_valid(low_packet_valid),
        .detect_add      (detect_add),
        .lfd_state       (lfd_state),
        .ld_state        (ld_state),
        .laf_state       (laf_state),
        .full_state      (full_state),
        .rst_int_reg     (rst_int_reg),
        .write_enb_reg   (write_enb_reg),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    // Output vector order: detect, lfd, ld, full, laf, rst_int, write_enb, busy
    logic [7:0] dut_v;
    assign dut_v = {detect_add, lfd_state, ld_state, full_state, laf_state,
                    rst_int_reg, write_enb_reg, busy};

    localparam int M_DA  = 0;
    localparam int M_LFD = 1;
    localparam int M_LD  = 2;
    localparam int M_FFS = 3;
    localparam int M_LAF = 4;
    localparam int M_LP  = 5;
    localparam int M_CPE = 6;
    localparam int M_WTE = 7;

    localparam logic [7:0] V_DA  = 8'b1000_0000;
    localparam logic [7:0] V_LFD = 8'b0100_0001;
    localparam logic [7:0] V_LD  = 8'b0010_0010;
    localparam logic [7:0] V_FFS = 8'b0001_0001;
    localparam logic [7:0] V_LAF = 8'b0000_1011;
    localparam logic [7:0] V_LP  = 8'b0000_0011;
    localparam logic [7:0] V_CPE = 8'b0000_0101;
    localparam logic [7:0] V_WTE = 8'b0000_0001;

    logic [7:0] exp_tab [8];
    initial begin
        exp_tab[M_DA]  = V_DA;
        exp_tab[M_LFD] = V_LFD;
        exp_tab[M_LD]  = V_LD;
        exp_tab[M_FFS] = V_FFS;
        exp_tab[M_LAF] = V_LAF;
        exp_tab[M_LP]  = V_LP;
        exp_tab[M_CPE] = V_CPE;
        exp_tab[M_WTE] = V_WTE;
    end

    int         ms     = M_DA;
    logic [1:0] maddr  = 2'd0;
    bit         mvalid = 1'b0;

    // Behavioural reference: packet-level rules applied at each rising edge
    always @(posedge clock) begin
        logic [2:0] empt;
        logic [2:0] sr;
        int         nxt;
        logic [1:0] na;
        empt = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        sr   = {soft_reset_2, soft_reset_1, soft_reset_0};
        if (reset) begin
            ms     = M_DA;
            maddr  = 2'd0;
            mvalid = 1'b1;
        end else begin
            nxt = ms;
            na  = maddr;
            if (ms == M_DA && pkt_valid && data_in != 2'd3) na = data_in;
            if (maddr != 2'd3 && sr[maddr]) begin
                nxt = M_DA;
            end else if (ms == M_DA) begin
                if (pkt_valid && data_in != 2'd3) nxt = empt[data_in] ? M_LFD : M_WTE;
            end else if (ms == M_LFD) begin
                nxt = M_LD;
            end else if (ms == M_LD) begin
                if (fifo_full) nxt = M_FFS;
                else if (!pkt_valid) nxt = M_LP;
            end else if (ms == M_FFS) begin
                if (!fifo_full) nxt = M_LAF;
            end else if (ms == M_LAF) begin
                nxt = parity_done ? M_DA : (low_packet_valid ? M_LP : M_LD);
            end else if (ms == M_LP) begin
                nxt = M_CPE;
            end else if (ms == M_CPE) begin
                nxt = fifo_full ? M_FFS : M_DA;
            end else if (ms == M_WTE) begin
                if (maddr != 2'd3 && empt[maddr]) nxt = M_LFD;
            end
            ms    = nxt;
            maddr = na;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (mvalid) begin
            checks++;
            if (dut_v !== exp_tab[ms]) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b model_state=%0d", $time, dut_v, exp_tab[ms], ms);
            end
        end
    end

    task automatic check_lit(input string name, input logic [7:0] exp);
        checks++;
        if (dut_v !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, dut_v, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step(); step();
        check_lit("reset_state", V_DA);

        // Normal packet to FIFO 1
        reset = 1'b0; pkt_valid = 1'b1; data_in = 2'b01;
        step(); check_lit("norm_lfd", V_LFD);
        step(); check_lit("norm_ld", V_LD);
        pkt_valid = 1'b0;
        step(); check_lit("norm_parity", V_LP);
        step(); check_lit("norm_check_parity", V_CPE);
        step(); check_lit("norm_back_decode", V_DA);

        // Busy destination FIFO 2
        pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); check_lit("wait_empty_busy", V_WTE);
        end
        fifo_empty_2 = 1'b1;
        step(); check_lit("wait_to_lfd", V_LFD);
        step(); check_lit("wait_then_ld", V_LD);

        // Full stall while loading
        fifo_full = 1'b1;
        step(); check_lit("stall_full", V_FFS);
        fifo_full = 1'b0;
        step(); check_lit("stall_laf", V_LAF);
        step(); check_lit("stall_back_ld", V_LD);

        // Full after parity, then parity_done exit from LOAD_AFTER_FULL
        pkt_valid = 1'b0;
        step(); check_lit("fap_parity", V_LP);
        fifo_full = 1'b1;
        step(); check_lit("fap_check", V_CPE);
        step(); check_lit("fap_full", V_FFS);
        fifo_full = 1'b0; parity_done = 1'b1;
        step(); check_lit("fap_laf", V_LAF);
        step(); check_lit("fap_parity_done", V_DA);
        parity_done = 1'b0;

        // Invalid address ignored
        pkt_valid = 1'b1; data_in = 2'b11;
        step(); check_lit("invalid_addr_1", V_DA);
        step(); check_lit("invalid_addr_2", V_DA);

        // Soft reset: only the selected FIFO's counts
        data_in = 2'b00;
        step(); check_lit("sr_lfd", V_LFD);
        step(); check_lit("sr_ld", V_LD);
        soft_reset_1 = 1'b1;
        step(); check_lit("sr_other_ignored", V_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step(); check_lit("sr_selected", V_DA);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        step(); check_lit("sr_idle", V_DA);

        // Reset in the middle of a stalled packet
        pkt_valid = 1'b1; data_in = 2'b01;
        step(); step();
        fifo_full = 1'b1;
        step(); check_lit("mid_full", V_FFS);
        reset = 1'b1;
        step(); check_lit("mid_reset", V_DA);
        fifo_full = 1'b0;
        step(); check_lit("mid_reset_hold", V_DA);
        reset = 1'b0; pkt_valid = 1'b0;
        step(); check_lit("mid_after", V_DA);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset            = ($urandom_range(0, 99) == 0);
            pkt_valid        = ($urandom_range(0, 3) != 0);
            data_in          = 2'($urandom_range(0, 3));
            fifo_full        = ($urandom_range(0, 3) == 0);
            fifo_empty_0     = ($urandom_range(0, 2) != 0);
            fifo_empty_1     = ($urandom_range(0, 2) != 0);
            fifo_empty_2     = ($urandom_range(0, 2) != 0);
            soft_reset_0     = ($urandom_range(0, 24) == 0);
            soft_reset_1     = ($urandom_range(0, 24) == 0);
            soft_reset_2     = ($urandom_range(0, 24) == 0);
            parity_done      = ($urandom_range(0, 3) == 0);
            low_packet_valid = ($urandom_range(0, 3) == 0);
            step();
        end

        idle_inputs();
        step(); step();
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
